uart_tx_cfg: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_tx_cfg.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter (and a future receiver).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Widest legal payload; narrower words are zero-extended, which leaves the XOR unchanged.
  localparam int MAX_DATA_W = 9;

  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input logic [1:0]            mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter; o_zero marks the last cycle of the current bit.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_value,
  output logic             o_zero
);

  logic [DIV_W-1:0] r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: runtime divisor, 1/2 stop bits, optional parity
// (parity present only when UART_TX_PARITY_EN is defined).
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div,
  input  logic [1:0]        parity_mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  uart_tx_state_t    r_state, w_state_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
  logic              r_stop_cnt, w_stop_cnt_next;
  logic [DIV_W-1:0]  r_div, w_load_value;
  logic              r_tx, w_tx_next;
  logic              w_load, w_bit_end, w_last_stop, w_frame_end, w_accept;

`ifdef UART_TX_PARITY_EN
  logic r_par_en, r_par_bit;
`else
  logic w_unused_parity_mode;
  assign w_unused_parity_mode = ^parity_mode;
`endif

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_load_value),
    .o_zero  (w_bit_end)
  );

  assign w_last_stop = (STOP_BITS == 1) || r_stop_cnt;
  assign w_frame_end = (r_state == STOP) && w_bit_end && w_last_stop;

  // Ready also in the final stop cycle so a held tx_valid starts the next frame with no idle gap.
  assign tx_ready = !rst && ((r_state == IDLE) || w_frame_end);
  assign tx_done  = !rst && w_frame_end;
  assign tx_busy  = (r_state != IDLE);
  assign tx       = r_tx;
  assign w_accept = tx_valid && tx_ready;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_load          = 1'b0;
    w_load_value    = r_div;

    case (r_state)
      IDLE: ;
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
          w_load       = 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_load = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_next  = '0;
            w_stop_cnt_next = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_state_next    = r_par_en ? PARITY : STOP;
`else
            w_state_next    = STOP;
`endif
          end else begin
            w_shift_next   = r_shift >> 1;
            w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_next = STOP;
          w_load       = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          if (w_last_stop) begin
            w_state_next = IDLE;
          end else begin
            w_stop_cnt_next = 1'b1;
            w_load          = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_accept) begin
      w_state_next    = START;
      w_shift_next    = tx_data;
      w_bit_cnt_next  = '0;
      w_stop_cnt_next = 1'b0;
      w_load          = 1'b1;
      w_load_value    = div;
    end

    // tx is registered from the next state so the line changes on the same edge as the FSM.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_next = r_par_bit;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_div      <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_tx       <= w_tx_next;
      if (w_accept) begin
        r_div <= div;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_accept) begin
      r_par_en  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      r_par_bit <= parity_bit(MAX_DATA_W'(tx_data), parity_mode);
    end
  end
`endif

endmodule
